// File: rtl/mac_array_os.sv
// Output-stationary N x N signed MAC array: accumulates outer products of a_vec x b_vec
// per tile and delivers the finished tile through a valid/ready output register bank.
module mac_array_os #(
    parameter int N   = 4,
    parameter int DW  = 8,
    parameter int AW  = 32,
    parameter int SAT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_first,
    input  logic                in_last,
    input  logic [N*DW-1:0]     a_vec,
    input  logic [N*DW-1:0]     b_vec,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*N*AW-1:0]   y_flat,
    output logic                ovf,
    output logic [15:0]         k_count,
    output logic                busy,
    output logic                proto_err
);

    localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    logic [AW-1:0]  acc_q   [N][N];
    logic [AW-1:0]  acc_nxt [N][N];
    logic [AW-1:0]  y_q     [N][N];
    logic [N*N-1:0] cell_ovf_vec;
    logic           tile_ovf_q;
    logic           tile_ovf_nxt;
    logic [15:0]    cnt_q;
    logic [15:0]    cnt_nxt;
    logic           accept;
    logic           start;

    assign in_ready = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    // A non-first beat arriving while idle is treated as the start of a new tile.
    assign start    = in_first || !busy;

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic signed [2*DW-1:0] prod;
            logic [AW:0]            base;
            logic [AW:0]            sum;
            logic                   cell_ovf;

            assign prod     = $signed(a_vec[i*DW +: DW]) * $signed(b_vec[j*DW +: DW]);
            assign base     = start ? '0 : {acc_q[i][j][AW-1], acc_q[i][j]};
            assign sum      = base + {{(AW+1-2*DW){prod[2*DW-1]}}, prod};
            assign cell_ovf = sum[AW] ^ sum[AW-1];
            assign cell_ovf_vec[i*N+j] = cell_ovf;
            assign acc_nxt[i][j] = (SAT != 0 && cell_ovf) ? (sum[AW] ? ACC_MIN : ACC_MAX)
                                                          : sum[AW-1:0];
            assign y_flat[(i*N+j)*AW +: AW] = y_q[i][j];
        end
    end

    assign tile_ovf_nxt = (start ? 1'b0 : tile_ovf_q) | (|cell_ovf_vec);
    assign cnt_nxt      = start ? 16'd1 : ((cnt_q == '1) ? cnt_q : cnt_q + 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    acc_q[i][j] <= '0;
                    y_q[i][j]   <= '0;
                end
            end
            tile_ovf_q <= 1'b0;
            cnt_q      <= '0;
            busy       <= 1'b0;
            proto_err  <= 1'b0;
            out_valid  <= 1'b0;
            ovf        <= 1'b0;
            k_count    <= '0;
        end else begin
            proto_err <= accept && (in_first == busy);
            if (accept) begin
                acc_q      <= acc_nxt;
                tile_ovf_q <= tile_ovf_nxt;
                cnt_q      <= cnt_nxt;
                busy       <= !in_last;
            end
            // in_ready guarantees the output bank is free or being drained when a last beat lands.
            if (accept && in_last) begin
                y_q       <= acc_nxt;
                ovf       <= tile_ovf_nxt;
                k_count   <= cnt_nxt;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
